tt_um_jimktrains_vslc_prescaler: RTL and testbench
==================================================

Name: tt_um_jimktrains_vslc_prescaler

Overview:
Tick source feeding the VSLC timer's timer_clk input. It divides either the system clock or an external pin event stream by a programmable divisor, and produces a square wave whose rising edges the timer counts. A shadowed divisor register allows glitch-free retuning while running: a new divisor takes effect only at a half-period boundary.

Parameters:
DIV_WIDTH, 16, width of divisor and internal counter
SYNC_STAGES, 2, flops in the ext_in synchroniser (min 2)
RESET_DIV, 0, divisor value loaded into active and shadow registers on reset

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  synchronous, active-low reset
enable  in  1  1 = run; 0 = hold outputs low, clear counter
src_sel  in  1  0 = count every clk; 1 = count ext_in edges
ext_in  in  1  asynchronous external event pin
ext_edge  in  1  0 = rising edges of ext_in count; 1 = falling edges
div_in  in  DIV_WIDTH  new divisor value
div_wr  in  1  one-cycle strobe; captures div_in into shadow
timer_clk  out  1  divided square wave, to timer
tick  out  1  one-cycle pulse on the same clk that timer_clk goes 0->1
div_pending  out  1  shadow written, not yet applied
div_active  out  DIV_WIDTH  divisor currently in use

Behaviour:
- One clock, clk. Reset is synchronous and active-low (rst_n), sampled on posedge clk.
- Reset values:
  - timer_clk=0, tick=0, div_pending=0.
  - div_active=shadow=RESET_DIV, counter=0.
  - All synchroniser and edge flops = 0.
- Synchroniser:
  - ext_in passes through SYNC_STAGES flops, then one history flop. It runs regardless of enable.
  - ext_event = (synced & ~hist) when ext_edge=0; (~synced & hist) when ext_edge=1.
  - Latency: ext_in transition to ext_event high is SYNC_STAGES+1 clk edges.
- Count event ce = enable & (src_sel ? ext_event : 1).
- On ce:
  - If counter == div_active (wrap):
    - counter <= 0; timer_clk <= ~timer_clk.
    - tick <= 1 if timer_clk was 0.
    - If div_pending: div_active <= shadow, div_pending <= 0.
  - Otherwise: counter <= counter + 1, modulo 2^DIV_WIDTH; no saturation.
- tick is 0 in every cycle not described above.
- Output period is 2*(div_active+1) count events. The high and low halves each last div_active+1 events.
- div_active=0 with src_sel=0 toggles every clk. A rising edge every 2 clks is the fastest rate the timer's edge detector supports.
- div_wr:
  - enable=1: shadow <= div_in, div_pending <= 1.
  - enable=0: div_active <= div_in and shadow <= div_in immediately; div_pending <= 0.
  - div_wr on the same cycle as a wrap: div_in goes directly to div_active, div_pending <= 0. The wrap itself compares against the old div_active.
  - Back-to-back div_wr while pending: last write wins.
- enable=0:
  - Counter <= 0, timer_clk <= 0, tick <= 0.
  - A pending shadow is applied to div_active and div_pending cleared.
  - On re-enable, counting restarts from counter 0, timer_clk low.
- src_sel or ext_edge changing mid-run: counter and timer_clk are not reset; the new source governs from the next cycle.
  - Changing ext_edge may produce one spurious or missed ext_event; accepted.
- rst_n low mid-operation overrides everything on that edge.

Decomposition:
- Shared package vslc_pkg:
  - DIV_WIDTH default constant.
  - Source-select encodings SRC_CLK=0, SRC_EXT=1.
  - Edge encodings EDGE_RISE=0, EDGE_FALL=1.
- One sub-module, vslc_sync_edge: SYNC_STAGES synchroniser plus edge detector, parameterised on stages, output ext_event. Reusable for other VSLC input pins.
- Divider, shadow and output logic stay in the top.

Test Plan:
1. Reset, enable=1, src_sel=0, div_wr with div_in=3 while disabled -> div_active=3 immediately. timer_clk high 4 clks, low 4 clks, period 8. tick pulses once per 8 clks, aligned to the 0->1 edge.
2. div_active=0, src_sel=0 -> timer_clk toggles every clk; tick every 2 clks.
3. Running at div=5, div_wr div_in=1 mid-half-period -> div_pending=1 until the next wrap. That half lasts 6 clks, subsequent halves 2 clks, and div_pending falls on the wrap cycle. Repeat with div_wr on the exact wrap cycle -> div_active=1 that cycle, div_pending never set.
4. src_sel=1, ext_edge=0, div=1, ext_in pulses 3 clks wide every 10 clks:
   - Each rising ext_in produces ext_event 3 clks later (SYNC_STAGES=2).
   - timer_clk toggles every 2nd ext pulse.
   - Switching to ext_edge=1 counts falling edges instead.
5. Enable dropped mid-high-phase with div_pending=1 -> next clk timer_clk=0, counter=0, div_active=shadow, div_pending=0. Re-enable restarts with a full low half.
6. rst_n=0 for one clk mid-run with div=7 -> all outputs 0, div_active=RESET_DIV; ext_in toggling during reset causes no tick.

Source files
------------

// File: rtl/vslc_pkg.sv
// Shared definitions for the VSLC timer block family.
//
// Contents:
//   DIV_WIDTH_DEFAULT  default width of prescaler divisor/counter
//   SRC_CLK / SRC_EXT  src_sel encodings (count clk / count ext_in edges)
//   EDGE_RISE / EDGE_FALL  ext_edge encodings
//   edge_detect()      single-cycle edge detect from synced + history bits
package vslc_pkg;

    localparam int DIV_WIDTH_DEFAULT = 16;

    localparam logic SRC_CLK   = 1'b0;
    localparam logic SRC_EXT   = 1'b1;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    // High for one cycle when the synchronised level has just made the
    // selected transition (history holds the previous synchronised level).
    function automatic logic edge_detect(
        input logic edge_sel,
        input logic synced,
        input logic hist
    );
        return (edge_sel == EDGE_FALL) ? (~synced & hist) : (synced & ~hist);
    endfunction

endpackage

// File: rtl/vslc_sync_edge.sv
// Synchroniser plus edge detector for an asynchronous VSLC input pin.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst_n      synchronous active-low reset; clears every flop
//   din        asynchronous input pin
//   edge_sel   EDGE_RISE: rising edges detected, EDGE_FALL: falling edges
//   ext_event  registered one-cycle pulse per detected edge
//
// A din transition shows up on ext_event SYNC_STAGES+1 clk edges later:
// SYNC_STAGES synchroniser flops, then the registered detector output.
// SYNC_STAGES must be at least 2 for metastability protection.
module vslc_sync_edge
    import vslc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic edge_sel,
    output logic ext_event
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;
    logic                   ext_event_reg;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (!rst_n) sync_reg[gi] <= 1'b0;
                    else        sync_reg[gi] <= din;
                end
            end else begin : g_chain
                always_ff @(posedge clk) begin
                    if (!rst_n) sync_reg[gi] <= 1'b0;
                    else        sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_reg      <= 1'b0;
            ext_event_reg <= 1'b0;
        end else begin
            hist_reg      <= sync_reg[SYNC_STAGES-1];
            ext_event_reg <= edge_detect(edge_sel, sync_reg[SYNC_STAGES-1], hist_reg);
        end
    end

    assign ext_event = ext_event_reg;

endmodule

// File: rtl/tt_um_jimktrains_vslc_prescaler.sv
// VSLC prescaler: tick source for the VSLC timer's timer_clk input.
//
// Divides clk (src_sel=SRC_CLK) or synchronised ext_in edges
// (src_sel=SRC_EXT) by a programmable divisor, producing a square wave
// whose halves each last div_active+1 count events.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   enable       1 = run; 0 = hold outputs low, clear counter
//   src_sel      count source select
//   ext_in       asynchronous external event pin
//   ext_edge     which ext_in edge counts (EDGE_RISE / EDGE_FALL)
//   div_in       new divisor value
//   div_wr       one-cycle strobe capturing div_in
//   timer_clk    divided square wave
//   tick         one-cycle pulse when timer_clk goes 0->1
//   div_pending  shadow holds a divisor not yet applied
//   div_active   divisor currently in use
//
// Divisor updates while running land in a shadow register and are only
// transferred at a half-period wrap, so the output never glitches.
module tt_um_jimktrains_vslc_prescaler
    import vslc_pkg::*;
#(
    parameter int          DIV_WIDTH   = DIV_WIDTH_DEFAULT,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned RESET_DIV   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 src_sel,
    input  logic                 ext_in,
    input  logic                 ext_edge,
    input  logic [DIV_WIDTH-1:0] div_in,
    input  logic                 div_wr,
    output logic                 timer_clk,
    output logic                 tick,
    output logic                 div_pending,
    output logic [DIV_WIDTH-1:0] div_active
);

    localparam logic [DIV_WIDTH-1:0] RESET_DIV_W = DIV_WIDTH'(RESET_DIV);

    logic                 ext_event;
    logic                 ce;
    logic                 wrap;

    logic [DIV_WIDTH-1:0] counter_reg,    counter_next;
    logic                 timer_clk_reg,  timer_clk_next;
    logic                 tick_reg,       tick_next;
    logic [DIV_WIDTH-1:0] div_active_reg, div_active_next;
    logic [DIV_WIDTH-1:0] shadow_reg,     shadow_next;
    logic                 div_pending_reg, div_pending_next;

    vslc_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (ext_in),
        .edge_sel  (ext_edge),
        .ext_event (ext_event)
    );

    assign ce   = enable & ((src_sel == SRC_EXT) ? ext_event : 1'b1);
    // Wrap always compares against the divisor in use this cycle, even if
    // a div_wr arrives on the same cycle.
    assign wrap = ce & (counter_reg == div_active_reg);

    always_comb begin
        counter_next     = counter_reg;
        timer_clk_next   = timer_clk_reg;
        tick_next        = 1'b0;
        div_active_next  = div_active_reg;
        shadow_next      = shadow_reg;
        div_pending_next = div_pending_reg;

        if (!enable) begin
            // Idle: nothing is being generated, so any divisor can be
            // applied straight away without risk of a glitch.
            counter_next     = '0;
            timer_clk_next   = 1'b0;
            div_pending_next = 1'b0;
            if (div_wr) begin
                div_active_next = div_in;
                shadow_next     = div_in;
            end else if (div_pending_reg) begin
                div_active_next = shadow_reg;
            end
        end else begin
            if (ce) begin
                if (wrap) begin
                    counter_next   = '0;
                    timer_clk_next = ~timer_clk_reg;
                    tick_next      = ~timer_clk_reg;
                end else begin
                    counter_next   = counter_reg + DIV_WIDTH'(1);
                end
            end

            if (div_wr) begin
                shadow_next = div_in;
                if (wrap) begin
                    // Already at a half-period boundary: apply directly.
                    div_active_next  = div_in;
                    div_pending_next = 1'b0;
                end else begin
                    div_pending_next = 1'b1;
                end
            end else if (wrap && div_pending_reg) begin
                div_active_next  = shadow_reg;
                div_pending_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter_reg     <= '0;
            timer_clk_reg   <= 1'b0;
            tick_reg        <= 1'b0;
            div_active_reg  <= RESET_DIV_W;
            shadow_reg      <= RESET_DIV_W;
            div_pending_reg <= 1'b0;
        end else begin
            counter_reg     <= counter_next;
            timer_clk_reg   <= timer_clk_next;
            tick_reg        <= tick_next;
            div_active_reg  <= div_active_next;
            shadow_reg      <= shadow_next;
            div_pending_reg <= div_pending_next;
        end
    end

    assign timer_clk   = timer_clk_reg;
    assign tick        = tick_reg;
    assign div_pending = div_pending_reg;
    assign div_active  = div_active_reg;

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_prescaler.sv
module tb_tt_um_jimktrains_vslc_prescaler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        src_sel;
    logic        ext_in;
    logic        ext_edge;
    logic [15:0] div_in;
    logic        div_wr;
    logic        timer_clk;
    logic        tick;
    logic        div_pending;
    logic [15:0] div_active;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tt_um_jimktrains_vslc_prescaler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .src_sel     (src_sel),
        .ext_in      (ext_in),
        .ext_edge    (ext_edge),
        .div_in      (div_in),
        .div_wr      (div_wr),
        .timer_clk   (timer_clk),
        .tick        (tick),
        .div_pending (div_pending),
        .div_active  (div_active)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock, then check timer_clk and tick 1 time unit after the edge.
    task automatic cyc(input string tag, input logic tc_e, input logic tk_e);
        @(posedge clk);
        #1;
        $display("%0t %s: timer_clk=%0b tick=%0b pend=%0b div=%0d", $time, tag,
                 timer_clk, tick, div_pending, div_active);
        chk({tag, ".timer_clk"}, {31'd0, timer_clk}, {31'd0, tc_e});
        chk({tag, ".tick"},      {31'd0, tick},      {31'd0, tk_e});
    endtask

    task automatic load_off(input logic [15:0] val);
        enable = 1'b0;
        div_in = val;
        div_wr = 1'b1;
        cyc("load", 1'b0, 1'b0);
        div_wr = 1'b0;
        chk("load.div_active", {16'd0, div_active}, {16'd0, val});
        chk("load.div_pending", {31'd0, div_pending}, 32'd0);
    endtask

    initial begin
        logic tcv;
        logic tk;

        rst_n = 1'b0; enable = 1'b0; src_sel = 1'b0; ext_in = 1'b0;
        ext_edge = 1'b0; div_in = '0; div_wr = 1'b0;

        // Reset state
        cyc("rst", 1'b0, 1'b0);
        cyc("rst", 1'b0, 1'b0);
        chk("rst.div_active", {16'd0, div_active}, 32'd0);
        chk("rst.div_pending", {31'd0, div_pending}, 32'd0);
        rst_n = 1'b1;

        // Divide by 3: halves of 4 clks, tick every 8
        load_off(16'd3);
        enable = 1'b1;
        for (int k = 1; k <= 24; k++)
            cyc("div3", ((k / 4) % 2) == 1, (k % 8) == 4);

        // Divide by 0: toggles every clk
        load_off(16'd0);
        enable = 1'b1;
        for (int k = 1; k <= 8; k++)
            cyc("div0", (k % 2) == 1, (k % 2) == 1);

        // Shadowed retune 5 -> 1 mid-half
        load_off(16'd5);
        enable = 1'b1;
        for (int k = 1; k <= 8; k++)
            cyc("div5", k >= 6, k == 6);
        div_in = 16'd1; div_wr = 1'b1;
        cyc("retune", 1'b1, 1'b0);
        div_wr = 1'b0;
        chk("retune.pending", {31'd0, div_pending}, 32'd1);
        chk("retune.div_active", {16'd0, div_active}, 32'd5);
        cyc("retune", 1'b1, 1'b0);
        chk("retune.pending2", {31'd0, div_pending}, 32'd1);
        cyc("retune", 1'b1, 1'b0);
        chk("retune.pending3", {31'd0, div_pending}, 32'd1);
        cyc("retune.wrap", 1'b0, 1'b0);
        chk("retune.wrap.pending", {31'd0, div_pending}, 32'd0);
        chk("retune.wrap.div_active", {16'd0, div_active}, 32'd1);
        cyc("div1", 1'b0, 1'b0);
        cyc("div1", 1'b1, 1'b1);
        cyc("div1", 1'b1, 1'b0);
        cyc("div1", 1'b0, 1'b0);
        cyc("div1", 1'b0, 1'b0);
        cyc("div1", 1'b1, 1'b1);
        cyc("div1", 1'b1, 1'b0);
        // div_wr exactly on the wrap cycle: applied directly
        div_in = 16'd4; div_wr = 1'b1;
        cyc("wrapwr", 1'b0, 1'b0);
        div_wr = 1'b0;
        chk("wrapwr.div_active", {16'd0, div_active}, 32'd4);
        chk("wrapwr.pending", {31'd0, div_pending}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            cyc("div4", 1'b0, 1'b0);
            chk("div4.pending", {31'd0, div_pending}, 32'd0);
        end
        cyc("div4", 1'b1, 1'b1);

        // External source, rising edges, div=1
        load_off(16'd1);
        src_sel = 1'b1; ext_edge = 1'b0;
        enable = 1'b1;
        tcv = 1'b0;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 10; i++) begin
                ext_in = (i < 3);
                tk = 1'b0;
                if (i == 3 && (p % 2) == 1) begin
                    tk  = ~tcv;
                    tcv = ~tcv;
                end
                cyc("ext_rise", tcv, tk);
            end
        end
        // Falling edges: event lands 3 clks after ext_in falls
        ext_edge = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 10; i++) begin
                ext_in = (i < 3);
                tk = 1'b0;
                if (i == 6 && (p % 2) == 1) begin
                    tk  = ~tcv;
                    tcv = ~tcv;
                end
                cyc("ext_fall", tcv, tk);
            end
        end
        src_sel = 1'b0; ext_edge = 1'b0; ext_in = 1'b0;

        // Disable mid-high with a pending divisor
        load_off(16'd3);
        enable = 1'b1;
        cyc("dis", 1'b0, 1'b0);
        cyc("dis", 1'b0, 1'b0);
        cyc("dis", 1'b0, 1'b0);
        cyc("dis", 1'b1, 1'b1);
        cyc("dis", 1'b1, 1'b0);
        div_in = 16'd6; div_wr = 1'b1;
        cyc("dis.wr", 1'b1, 1'b0);
        div_wr = 1'b0;
        chk("dis.pending", {31'd0, div_pending}, 32'd1);
        chk("dis.div_active", {16'd0, div_active}, 32'd3);
        enable = 1'b0;
        cyc("dis.off", 1'b0, 1'b0);
        chk("dis.off.div_active", {16'd0, div_active}, 32'd6);
        chk("dis.off.pending", {31'd0, div_pending}, 32'd0);
        enable = 1'b1;
        for (int k = 1; k <= 6; k++)
            cyc("reen", 1'b0, 1'b0);
        cyc("reen", 1'b1, 1'b1);

        // Reset mid-run at div=7, ext_in toggling during reset
        load_off(16'd7);
        enable = 1'b1;
        for (int k = 1; k <= 7; k++)
            cyc("div7", 1'b0, 1'b0);
        cyc("div7", 1'b1, 1'b1);
        cyc("div7", 1'b1, 1'b0);
        src_sel = 1'b1;
        rst_n = 1'b0; ext_in = 1'b1;
        cyc("midrst", 1'b0, 1'b0);
        chk("midrst.div_active", {16'd0, div_active}, 32'd0);
        chk("midrst.pending", {31'd0, div_pending}, 32'd0);
        rst_n = 1'b1; ext_in = 1'b0;
        for (int k = 1; k <= 6; k++)
            cyc("postrst", 1'b0, 1'b0);
        // A genuine ext pulse after reset still counts (div 0 -> immediate wrap)
        for (int i = 0; i < 5; i++) begin
            ext_in = (i < 2);
            cyc("postrst.ext", i >= 3, i == 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
